icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative, read-only instruction cache between datapath fetch and the memory controller.
//  Configurable sets, ways and words per block; true-LRU replacement; multi-word block refill FSM; whole-cache flush.
//  Drop-in for the fixed direct-mapped icache inside the caches wrapper; same datapath/memory-side signal meanings.
// PARAMETERS
//  SETS      8  number of sets, power of 2, >=2
//  WAYS      2  associativity, one of 1,2,4
//  BLKWORDS  2  32-bit words per block, power of 2, >=1
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   reset, asynchronous, active-low
//  imemREN    in   1   datapath fetch request
//  imemaddr   in   32  fetch byte address, bits[1:0] ignored
//  flush      in   1   invalidate entire cache
//  ihit       out  1   fetch data valid this cycle
//  imemload   out  32  fetched instruction
//  iREN       out  1   memory read request
//  iaddr      out  32  memory read byte address
//  iload      in   32  memory read data
//  iwait      in   1   memory busy; data valid when iREN & ~iwait
//  hit_count  out  32  (ICACHE_PERF_EN only) hits since reset/flush
//  miss_count out  32  (ICACHE_PERF_EN only) misses since reset/flush
// BEHAVIOUR
//  Address split: [1:0] byte, next BOFF_W=$clog2(BLKWORDS) word-in-block, next IDX_W=$clog2(SETS) index, rest tag.
//  Reset (nRST=0, async): all valid=0, LRU ages=0, state IDLE, word counter 0; ihit=0, imemload=0, iREN=0, iaddr=0.
//  Lookup combinational: ihit = (state==IDLE) & imemREN & ~flush & any way valid with tag match; imemload = hit word,
//   else 0. Hit latency 0 cycles. Hit updates LRU at clock edge (hit way -> age 0, younger ways age+1).
//  FSM IDLE: imemREN & no hit & ~flush -> latch tag/index, choose victim, counter=0, go FILL.
//   Victim = lowest-index invalid way; if all valid, way with max age (tie impossible under true LRU).
//  FSM FILL: iREN=1, iaddr={latched tag,index,counter,2'b00}; ihit=0 throughout.
//   iwait=1: hold. iwait=0: write iload into victim word[counter], counter++.
//   Last word accepted: set victim valid+tag, victim becomes MRU, go IDLE; lookup hits next cycle (miss = 1+ fill cycles).
//  Fill uses latched address; imemaddr/imemREN changes during FILL ignored until return to IDLE.
//  flush=1 (any state): next edge clears all valid bits and ages, aborts FILL (iREN=0 combinationally that cycle,
//   partially written block stays invalid), state IDLE; flush beats a simultaneous miss or fill completion.
//  WAYS=1: no LRU storage, victim always way 0. BLKWORDS=1: fill is single word.
//  Data array write and tag write on same edge of final word; no read-during-write forwarding needed (ihit=0 in FILL).
// CONFIGURATION
//  ICACHE_PERF_EN defined: hit_count/miss_count ports exist; hit_count +1 on each cycle ihit=1; miss_count +1 on each
//   IDLE->FILL transition; both wrap at 2^32; cleared by reset and flush.
//  ICACHE_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  cpu_types_pkg gains: icache_state_t {IDLE,FILL}; word_t reuse; localparam-free typedef helpers not shared.
//  Per-instance types (tag, index, frame struct {valid,tag,data[BLKWORDS]}) stay local: depend on parameters.
//  Sub-module icache_lru: per-set age array, inputs set/touch way/flush, outputs victim way; bypassed when WAYS=1.
// TESTING
//  Reset then fetch 0x0000_0040 (SETS=8,WAYS=2,BLKWORDS=2): miss, iaddr 0x40 then 0x44, ihit next cycle, load=mem[0x40].
//  Refetch 0x44 after fill: ihit same cycle, iREN stays 0, imemload=mem[0x44].
//  Fetch 0x040,0x080,0x040,0x0C0 (same set): third hits; 0x0C0 evicts way of 0x080 (LRU); then 0x040 hits, 0x080 misses.
//  iwait held high 5 cycles per word during fill: iaddr stable, ihit 0, fill completes after final ~iwait.
//  flush asserted mid-fill of 0x100: iREN low same cycle, next fetch 0x100 misses and refills from word 0.
//  ICACHE_PERF_EN: sequence miss,hit,hit,miss -> hit_count=2, miss_count=2; flush -> both 0.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache.
// Purely declarative: no logic, no latency.
// No flow control; consumed by the cache, its interface and its LRU sub-block.
package icache_assoc_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Wires only, zero latency.
// Memory stalls the cache through iwait; the datapath stalls on ihit=0.
interface icache_assoc_if;
   import icache_assoc_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  flush;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   word_t iload;
   logic  iwait;

   // datapath + memory controller side
   modport master (
      output imemREN, imemaddr, flush, iload, iwait,
      input  ihit, imemload, iREN, iaddr
   );

   // cache side
   modport slave (
      input  imemREN, imemaddr, flush, iload, iwait,
      output ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_assoc_lru.sv
// True-LRU age tracker: one age per way per set, oldest way reported as victim.
// Victim is combinational from look_set; touches and flush take effect at the next edge.
// No flow control; the touched way becomes age 0, every way no older than it ages by one.
module icache_assoc_lru #(
   parameter int SETS = 8,
   parameter int WAYS = 2
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      flush,
   input  logic                      touch,
   input  logic [$clog2(SETS)-1:0]   touch_set,
   input  logic [$clog2(WAYS)-1:0]   touch_way,
   input  logic [$clog2(SETS)-1:0]   look_set,
   output logic [$clog2(WAYS)-1:0]   victim
);
   localparam int AW = $clog2(WAYS);

   logic [AW-1:0] age_q [SETS][WAYS];

   // Age update. Ways that share the touched way's age are still-invalid ways, so
   // ageing them too keeps the valid ways' ages a strict permutation.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= '0;
      end else if (flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= '0;
      end else if (touch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == touch_way)
               age_q[touch_set][w] <= '0;
            else if (age_q[touch_set][w] <= age_q[touch_set][touch_way])
               age_q[touch_set][w] <= age_q[touch_set][w] + AW'(1);
         end
      end
   end

   // Oldest way in the looked-up set.
   always_comb begin
      victim = '0;
      for (int w = 1; w < WAYS; w++)
         if (age_q[look_set][w] > age_q[look_set][victim])
            victim = AW'(w);
   end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with true-LRU and multi-word block refill.
// Hits return data combinationally (0 cycles); a miss costs 1 + BLKWORDS*(1+wait) cycles.
// Memory stalls hold the FILL word via iwait; flush aborts any fill. Optional ICACHE_PERF_EN adds hit/miss counters.
module icache_assoc
   import icache_assoc_pkg::*;
#(
   parameter int SETS     = 8,
   parameter int WAYS     = 2,
   parameter int BLKWORDS = 2
) (
   input  logic          CLK,
   input  logic          nRST,
   icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
   ,
   output word_t         hit_count,
   output word_t         miss_count
`endif
);
   localparam int BOFF_W = $clog2(BLKWORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 30 - BOFF_W - IDX_W;
   localparam int CNT_W  = (BOFF_W > 0) ? BOFF_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef struct packed {
      logic                     valid;
      tag_t                     tag;
      word_t [BLKWORDS-1:0]     data;
   } frame_t;

   frame_t             frames [SETS][WAYS];
   icache_state_t      state_q, state_d;
   tag_t               tag_q, a_tag;
   idx_t               idx_q, a_idx;
   logic [CNT_W-1:0]   cnt_q, a_off;
   logic [WAY_W-1:0]   vic_q, hit_way, inv_way, lru_way, victim;
   logic               hit_any, inv_any, hit, mem_ren, start, accept, last, fill_done;
   word_t              fill_addr;
   logic               unused_byte;

   assign a_tag       = bus.imemaddr[31 -: TAG_W];
   assign a_idx       = bus.imemaddr[2+BOFF_W +: IDX_W];
   assign unused_byte = ^bus.imemaddr[1:0];

   generate
      if (BOFF_W > 0) begin : g_off
         assign a_off     = bus.imemaddr[2 +: BOFF_W];
         assign fill_addr = {tag_q, idx_q, cnt_q, 2'b00};
      end else begin : g_nooff
         assign a_off     = '0;
         assign fill_addr = {tag_q, idx_q, 2'b00};
      end
   endgenerate

   // Tag compare across the indexed set; also find the lowest invalid way for replacement.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (frames[a_idx][w].valid && frames[a_idx][w].tag == a_tag) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!frames[a_idx][w].valid) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
   end

   generate
      if (WAYS > 1) begin : g_lru
         icache_assoc_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
            .CLK       (CLK),
            .nRST      (nRST),
            .flush     (bus.flush),
            .touch     (hit | fill_done),
            .touch_set (hit ? a_idx : idx_q),
            .touch_way (hit ? hit_way : vic_q),
            .look_set  (a_idx),
            .victim    (lru_way)
         );
      end else begin : g_nolru
         assign lru_way = '0;
      end
   endgenerate

   assign victim    = inv_any ? inv_way : lru_way;
   assign last      = (cnt_q == CNT_W'(BLKWORDS - 1));
   assign start     = (state_q == IDLE) & bus.imemREN & ~hit_any & ~bus.flush;
   assign accept    = (state_q == FILL) & ~bus.iwait & ~bus.flush;
   assign fill_done = accept & last;

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and handshake outputs; flush always wins and forces IDLE.
   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      mem_ren = 1'b0;
      case (state_q)
         IDLE: begin
            hit = bus.imemREN & ~bus.flush & hit_any;
            if (start) state_d = FILL;
         end
         FILL: begin
            mem_ren = ~bus.flush;
            if (fill_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   assign bus.ihit     = hit;
   assign bus.imemload = hit ? frames[a_idx][hit_way].data[a_off] : '0;
   assign bus.iREN     = mem_ren;
   assign bus.iaddr    = (state_q == FILL) ? fill_addr : '0;

   // Miss context: latched address and victim, plus the word counter of the refill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tag_q <= '0;
         idx_q <= '0;
         vic_q <= '0;
         cnt_q <= '0;
      end else if (bus.flush) begin
         cnt_q <= '0;
      end else if (start) begin
         tag_q <= a_tag;
         idx_q <= a_idx;
         vic_q <= victim;
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Frame array: refill words land in the victim; tag and valid go in with the last word.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               frames[s][w] <= '0;
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               frames[s][w].valid <= 1'b0;
      end else if (accept) begin
         frames[idx_q][vic_q].data[cnt_q] <= bus.iload;
         if (last) begin
            frames[idx_q][vic_q].valid <= 1'b1;
            frames[idx_q][vic_q].tag   <= tag_q;
         end
      end
   end

`ifdef ICACHE_PERF_EN
   // Hit cycles and fill starts since reset or the last flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (bus.flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit)   hit_count  <= hit_count + 32'd1;
         if (start) miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: reference cache model (timestamps for LRU) checked every cycle,
// plus directed sequences with hand-computed addresses and latencies.
module tb_icache_assoc;
   import icache_assoc_pkg::*;

   localparam int SETS = 8;
   localparam int WAYS = 2;
   localparam int BLKW = 2;
   localparam int BOFF = $clog2(BLKW);
   localparam int IDXW = $clog2(SETS);

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   icache_assoc_if bus();
`ifdef ICACHE_PERF_EN
   word_t hit_count, miss_count;
`endif

   icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic word_t memfn(input word_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // ---------------- reference model ----------------
   bit          model_on = 1'b0;
   bit          mv [SETS][WAYS];
   int unsigned mt [SETS][WAYS];
   longint      ms [SETS][WAYS];
   longint      tnow;
   bit          busy;
   int          fset, fway, fcnt;
   int unsigned ftag;
   word_t       fbase;
   int unsigned mhits, mmiss;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w] = 1'b0;
            ms[s][w] = 0;
         end
      busy = 1'b0; tnow = 0; mhits = 0; mmiss = 0;
   endtask

   task automatic model_step();
      word_t a;
      int s, hw, v;
      int unsigned tg;
      bit h;
      a  = bus.imemaddr;
      s  = int'((a >> (2 + BOFF)) % SETS);
      tg = a >> (2 + BOFF + IDXW);
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (mv[s][w] && mt[s][w] == tg) hw = w;
      h = !busy && bus.imemREN && !bus.flush && (hw >= 0);
      chk("ihit", bus.ihit, h);
      chk("imemload", bus.imemload, h ? memfn(a & ~32'h3) : 32'h0);
      chk("iREN", bus.iREN, busy && !bus.flush);
      chk("iaddr", bus.iaddr, busy ? fbase + word_t'(4 * fcnt) : 32'h0);
`ifdef ICACHE_PERF_EN
      chk("hit_count", hit_count, mhits);
      chk("miss_count", miss_count, mmiss);
`endif
      if (bus.flush) begin
         for (int ss = 0; ss < SETS; ss++)
            for (int w = 0; w < WAYS; w++) begin
               mv[ss][w] = 1'b0;
               ms[ss][w] = 0;
            end
         busy = 1'b0; mhits = 0; mmiss = 0;
      end else if (!busy) begin
         if (h) begin
            tnow++; ms[s][hw] = tnow; mhits++;
         end else if (bus.imemREN) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--)
               if (!mv[s][w]) v = w;
            if (v < 0) begin
               v = 0;
               for (int w = 1; w < WAYS; w++)
                  if (ms[s][w] < ms[s][v]) v = w;
            end
            busy = 1'b1; fset = s; fway = v; ftag = tg; fcnt = 0;
            fbase = a & ~word_t'(BLKW * 4 - 1);
            mmiss++;
         end
      end else if (!bus.iwait) begin
         fcnt++;
         if (fcnt == BLKW) begin
            mv[fset][fway] = 1'b1; mt[fset][fway] = ftag;
            tnow++; ms[fset][fway] = tnow; busy = 1'b0;
         end
      end
   endtask

   // Single compare process: inputs change at negedge, checked 2 time units later.
   always begin
      @(negedge CLK);
      #2;
      if (model_on && nRST) model_step();
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic ren, input word_t a, input logic fl, input logic w);
      @(negedge CLK);
      bus.imemREN  = ren;
      bus.imemaddr = a;
      bus.flush    = fl;
      bus.iwait    = w;
      bus.iload    = memfn(bus.iaddr);
      #3;
   endtask

   // Hold a fetch until ihit (bounded); n = cycles before the hit, -1 on timeout.
   task automatic fetch(input word_t a, input int w, output int n);
      int hold;
      hold = 0;
      n = -1;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         bus.imemREN  = 1'b1;
         bus.imemaddr = a;
         bus.flush    = 1'b0;
         if (bus.iREN) begin
            bus.iwait = (hold < w);
            hold = bus.iwait ? hold + 1 : 0;
         end else begin
            bus.iwait = 1'b0;
         end
         bus.iload = memfn(bus.iaddr);
         #3;
         if (bus.ihit) begin
            n = c;
            break;
         end
      end
   endtask

   // Start a miss, let the fill finish with fetch deasserted so no hit is taken.
   task automatic miss_only(input word_t a);
      cyc(1'b1, a, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b0);
         if (!bus.iREN) break;
      end
   endtask

   int    n;
   word_t ra;

   initial begin
      bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
      bus.iwait = 1'b0; bus.iload = '0;
      repeat (3) @(negedge CLK);
      chk("rst_ihit", bus.ihit, 32'h0);
      chk("rst_imemload", bus.imemload, 32'h0);
      chk("rst_iREN", bus.iREN, 32'h0);
      chk("rst_iaddr", bus.iaddr, 32'h0);
      model_reset();
      nRST = 1'b1;
      model_on = 1'b1;

      // first miss on 0x40: two-word fill then a hit
      cyc(1'b1, 32'h40, 1'b0, 1'b0);
      chk("m40_c0_ihit", bus.ihit, 32'h0);
      chk("m40_c0_iREN", bus.iREN, 32'h0);
      cyc(1'b1, 32'h40, 1'b0, 1'b0);
      chk("m40_c1_iREN", bus.iREN, 32'h1);
      chk("m40_c1_iaddr", bus.iaddr, 32'h40);
      cyc(1'b1, 32'h40, 1'b0, 1'b0);
      chk("m40_c2_iaddr", bus.iaddr, 32'h44);
      cyc(1'b1, 32'h40, 1'b0, 1'b0);
      chk("m40_c3_ihit", bus.ihit, 32'h1);
      chk("m40_c3_load", bus.imemload, memfn(32'h40));
      cyc(1'b1, 32'h44, 1'b0, 1'b0);
      chk("h44_ihit", bus.ihit, 32'h1);
      chk("h44_iREN", bus.iREN, 32'h0);
      chk("h44_load", bus.imemload, memfn(32'h44));

      // same-set LRU replacement
      fetch(32'h80, 0, n); chk("lru_80_lat", n, 3);
      fetch(32'h40, 0, n); chk("lru_40_lat", n, 0);
      fetch(32'hC0, 0, n); chk("lru_C0_lat", n, 3);
      fetch(32'h40, 0, n); chk("lru_40b_lat", n, 0);
      fetch(32'h80, 0, n); chk("lru_80b_lat", n, 3);

      // five wait cycles per word
      fetch(32'h300, 5, n); chk("wait_lat", n, 13);

      // flush in the middle of a fill
      cyc(1'b1, 32'h100, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("fl_w0_iaddr", bus.iaddr, 32'h100);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_iREN", bus.iREN, 32'h0);
      cyc(1'b1, 32'h100, 1'b0, 1'b0);
      chk("fl_remiss", bus.ihit, 32'h0);
      cyc(1'b1, 32'h100, 1'b0, 1'b0);
      chk("fl_refill_iaddr", bus.iaddr, 32'h100);
      fetch(32'h100, 0, n); chk("fl_refill_lat", n, 1);

`ifdef ICACHE_PERF_EN
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      miss_only(32'h600);
      cyc(1'b1, 32'h600, 1'b0, 1'b0);
      cyc(1'b1, 32'h604, 1'b0, 1'b0);
      miss_only(32'h640);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("perf_hits", hit_count, 32'd2);
      chk("perf_misses", miss_count, 32'd2);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("perf_hits_flush", hit_count, 32'd0);
      chk("perf_misses_flush", miss_count, 32'd0);
`endif

      // randomized traffic over a small address pool
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         ra = (word_t'($urandom_range(3)) << (2 + BOFF + IDXW))
            | (word_t'($urandom_range(3)) << (2 + BOFF))
            | (word_t'($urandom_range(BLKW - 1)) << 2)
            | word_t'($urandom_range(3));
         bus.imemREN  = ($urandom_range(3) != 0);
         bus.imemaddr = ra;
         bus.flush    = ($urandom_range(63) == 0);
         bus.iwait    = ($urandom_range(2) == 0);
         bus.iload    = memfn(bus.iaddr);
      end

      // asynchronous reset during a stalled fill
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      miss_only(32'h40);
      cyc(1'b1, 32'h500, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk("ar_pre_iREN", bus.iREN, 32'h1);
      model_on = 1'b0;
      nRST = 1'b0;
      #1;
      chk("ar_iREN", bus.iREN, 32'h0);
      chk("ar_iaddr", bus.iaddr, 32'h0);
      chk("ar_ihit", bus.ihit, 32'h0);
      @(negedge CLK);
      bus.imemREN = 1'b0; bus.iwait = 1'b0;
      model_reset();
      nRST = 1'b1;
      model_on = 1'b1;
      fetch(32'h40, 0, n); chk("ar_post_lat", n, 3);

      @(negedge CLK);
      bus.imemREN = 1'b0;
      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
